// File: rtl/iob_bus_merge.sv
// Merges an instruction and a data IOb master onto one memory port.
// Uses round-robin arbitration with a grant lock that holds a stalled request steady.
module iob_bus_merge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,

  input  logic                ibus_avalid_i,
  input  logic [ADDR_W-1:0]   ibus_addr_i,
  input  logic [DATA_W-1:0]   ibus_wdata_i,
  input  logic [DATA_W/8-1:0] ibus_wstrb_i,
  output logic [DATA_W-1:0]   ibus_rdata_o,
  output logic                ibus_rvalid_o,
  output logic                ibus_ready_o,

  input  logic                dbus_avalid_i,
  input  logic [ADDR_W-1:0]   dbus_addr_i,
  input  logic [DATA_W-1:0]   dbus_wdata_i,
  input  logic [DATA_W/8-1:0] dbus_wstrb_i,
  output logic [DATA_W-1:0]   dbus_rdata_o,
  output logic                dbus_rvalid_o,
  output logic                dbus_ready_o,

  output logic                mem_avalid_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_rvalid_i,
  input  logic                mem_ready_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_I = 2'd1;
  localparam logic [1:0] WAIT_D = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [1:0] state_reg, state_next;
  logic       last_grant_reg, last_grant_next;
  logic       lock_reg, lock_next;
  logic       lock_grant_reg, lock_grant_next;

  logic       grant;
  logic       arb_en;
  logic       accept;
  logic       is_write;
  logic [1:0] ready_vec;
  logic [1:0] rvalid_vec;

  // A locked grant wins over round-robin so a stalled request cannot be swapped out.
  always_comb begin
    grant = GNT_I;
    if (lock_reg) begin
      grant = lock_grant_reg;
    end else if (ibus_avalid_i && dbus_avalid_i) begin
      grant = ~last_grant_reg;
    end else if (dbus_avalid_i) begin
      grant = GNT_D;
    end
  end

  // Gating with cke_i keeps masters from seeing a handshake that the frozen registers would miss.
  assign arb_en = rst_n_i & cke_i & ((state_reg == IDLE) | mem_rvalid_i);

  always_comb begin
    mem_avalid_o = 1'b0;
    mem_addr_o   = ibus_addr_i;
    mem_wdata_o  = ibus_wdata_i;
    mem_wstrb_o  = ibus_wstrb_i;
    if (grant == GNT_D) begin
      mem_addr_o  = dbus_addr_i;
      mem_wdata_o = dbus_wdata_i;
      mem_wstrb_o = dbus_wstrb_i;
      mem_avalid_o = arb_en & dbus_avalid_i;
    end else begin
      mem_avalid_o = arb_en & ibus_avalid_i;
    end
  end

  assign accept   = mem_avalid_o & mem_ready_i;
  assign is_write = |mem_wstrb_o;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign ready_vec[gi]  = arb_en & mem_ready_i & (grant == 1'(gi));
      assign rvalid_vec[gi] = rst_n_i & mem_rvalid_i &
                              (state_reg == ((gi == 0) ? WAIT_I : WAIT_D));
    end
  endgenerate

  assign ibus_ready_o  = ready_vec[0];
  assign dbus_ready_o  = ready_vec[1];
  assign ibus_rvalid_o = rvalid_vec[0];
  assign dbus_rvalid_o = rvalid_vec[1];
  assign ibus_rdata_o  = mem_rdata_i;
  assign dbus_rdata_o  = mem_rdata_i;

  // A response in a wait state retires that read; a new read accepted alongside it starts the next wait.
  always_comb begin
    state_next = state_reg;
    if ((state_reg == IDLE) || mem_rvalid_i) begin
      state_next = IDLE;
      if (accept && !is_write) begin
        state_next = (grant == GNT_D) ? WAIT_D : WAIT_I;
      end
    end
  end

  always_comb begin
    lock_next       = lock_reg;
    lock_grant_next = lock_grant_reg;
    last_grant_next = last_grant_reg;
    if (accept) begin
      lock_next       = 1'b0;
      last_grant_next = grant;
    end else if (mem_avalid_o && !mem_ready_i) begin
      lock_next       = 1'b1;
      lock_grant_next = grant;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_D;
      lock_reg       <= 1'b0;
      lock_grant_reg <= GNT_I;
    end else if (cke_i) begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      lock_reg       <= lock_next;
      lock_grant_reg <= lock_grant_next;
    end
  end

endmodule

// File: tb/tb_iob_bus_merge.sv
// Directed-vector bench for iob_bus_merge; each task covers one scenario.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_iob_bus_merge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          cke_i;
  logic          ibus_avalid_i;
  logic [AW-1:0] ibus_addr_i;
  logic [DW-1:0] ibus_wdata_i;
  logic [DW/8-1:0] ibus_wstrb_i;
  logic [DW-1:0] ibus_rdata_o;
  logic          ibus_rvalid_o;
  logic          ibus_ready_o;
  logic          dbus_avalid_i;
  logic [AW-1:0] dbus_addr_i;
  logic [DW-1:0] dbus_wdata_i;
  logic [DW/8-1:0] dbus_wstrb_i;
  logic [DW-1:0] dbus_rdata_o;
  logic          dbus_rvalid_o;
  logic          dbus_ready_o;
  logic          mem_avalid_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW/8-1:0] mem_wstrb_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_rvalid_i;
  logic          mem_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  iob_bus_merge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i),
    .ibus_avalid_i(ibus_avalid_i), .ibus_addr_i(ibus_addr_i),
    .ibus_wdata_i(ibus_wdata_i), .ibus_wstrb_i(ibus_wstrb_i),
    .ibus_rdata_o(ibus_rdata_o), .ibus_rvalid_o(ibus_rvalid_o), .ibus_ready_o(ibus_ready_o),
    .dbus_avalid_i(dbus_avalid_i), .dbus_addr_i(dbus_addr_i),
    .dbus_wdata_i(dbus_wdata_i), .dbus_wstrb_i(dbus_wstrb_i),
    .dbus_rdata_o(dbus_rdata_o), .dbus_rvalid_o(dbus_rvalid_o), .dbus_ready_o(dbus_ready_o),
    .mem_avalid_o(mem_avalid_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .mem_ready_i(mem_ready_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cke_i = 1'b1;
    ibus_avalid_i = 1'b0; ibus_addr_i = '0; ibus_wdata_i = '0; ibus_wstrb_i = '0;
    dbus_avalid_i = 1'b0; dbus_addr_i = '0; dbus_wdata_i = '0; dbus_wstrb_i = '0;
    mem_rdata_i = '0; mem_rvalid_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    ibus_avalid_i = 1'b1; dbus_avalid_i = 1'b1; mem_ready_i = 1'b1; mem_rvalid_i = 1'b1;
    step();
    n_checks++; if (ibus_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ibus_ready: got %b want 0", ibus_ready_o); end
    n_checks++; if (dbus_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_dbus_ready: got %b want 0", dbus_ready_o); end
    n_checks++; if (ibus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ibus_rvalid: got %b want 0", ibus_rvalid_o); end
    n_checks++; if (dbus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_dbus_rvalid: got %b want 0", dbus_rvalid_o); end
    rst_n_i = 1'b1;
    idle_inputs();
    $display("test_reset done");
  endtask

  task automatic test_ibus_read();
    apply_reset();
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h100; mem_ready_i = 1'b1;
    #1;
    n_checks++; if (mem_avalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_mem_avalid: got %b want 1", mem_avalid_o); end
    n_checks++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 00000100", mem_addr_o); end
    n_checks++; if (ibus_ready_o !== 1'b1) begin n_fail++; $display("FAIL rd_ibus_ready: got %b want 1", ibus_ready_o); end
    n_checks++; if (dbus_ready_o !== 1'b0) begin n_fail++; $display("FAIL rd_dbus_ready: got %b want 0", dbus_ready_o); end
    step();
    // waiting with no response: request path must be shut
    #1;
    n_checks++; if (mem_avalid_o !== 1'b0) begin n_fail++; $display("FAIL wait_mem_avalid: got %b want 0", mem_avalid_o); end
    n_checks++; if (ibus_ready_o !== 1'b0) begin n_fail++; $display("FAIL wait_ibus_ready: got %b want 0", ibus_ready_o); end
    step();
    ibus_avalid_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    n_checks++; if (ibus_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_ibus_rvalid: got %b want 1", ibus_rvalid_o); end
    n_checks++; if (ibus_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_ibus_rdata: got %h want deadbeef", ibus_rdata_o); end
    n_checks++; if (dbus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_dbus_rvalid: got %b want 0", dbus_rvalid_o); end
    step();
    idle_inputs();
    $display("test_ibus_read done");
  endtask

  task automatic test_contention();
    apply_reset();
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h10;
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h20; mem_ready_i = 1'b1;
    #1;
    n_checks++; if (mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL rr1_addr: got %h want 00000010", mem_addr_o); end
    n_checks++; if (ibus_ready_o !== 1'b1 || dbus_ready_o !== 1'b0) begin n_fail++; $display("FAIL rr1_ready: got i=%b d=%b want i=1 d=0", ibus_ready_o, dbus_ready_o); end
    step();
    mem_rvalid_i = 1'b1;
    #1;
    n_checks++; if (mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL rr2_addr: got %h want 00000020", mem_addr_o); end
    n_checks++; if (ibus_ready_o !== 1'b0 || dbus_ready_o !== 1'b1) begin n_fail++; $display("FAIL rr2_ready: got i=%b d=%b want i=0 d=1", ibus_ready_o, dbus_ready_o); end
    n_checks++; if (ibus_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rr2_ibus_rvalid: got %b want 1", ibus_rvalid_o); end
    step();
    #1;
    n_checks++; if (mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL rr3_addr: got %h want 00000010", mem_addr_o); end
    n_checks++; if (ibus_ready_o !== 1'b1 || dbus_ready_o !== 1'b0) begin n_fail++; $display("FAIL rr3_ready: got i=%b d=%b want i=1 d=0", ibus_ready_o, dbus_ready_o); end
    n_checks++; if (dbus_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rr3_dbus_rvalid: got %b want 1", dbus_rvalid_o); end
    step();
    ibus_avalid_i = 1'b0; dbus_avalid_i = 1'b0;
    step();
    idle_inputs();
    $display("test_contention done");
  endtask

  task automatic test_lock();
    apply_reset();
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h200; mem_ready_i = 1'b0;
    #1;
    n_checks++; if (mem_addr_o !== 32'h200 || dbus_ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_c1: got addr=%h dready=%b want 00000200 0", mem_addr_o, dbus_ready_o); end
    step();
    // ibus would win round-robin here; the lock must keep dbus on the port
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h300;
    #1;
    n_checks++; if (mem_addr_o !== 32'h200) begin n_fail++; $display("FAIL lock_c2_addr: got %h want 00000200", mem_addr_o); end
    step();
    #1;
    n_checks++; if (mem_addr_o !== 32'h200) begin n_fail++; $display("FAIL lock_c3_addr: got %h want 00000200", mem_addr_o); end
    step();
    mem_ready_i = 1'b1;
    #1;
    n_checks++; if (mem_addr_o !== 32'h200) begin n_fail++; $display("FAIL lock_c4_addr: got %h want 00000200", mem_addr_o); end
    n_checks++; if (dbus_ready_o !== 1'b1 || ibus_ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_c4_ready: got i=%b d=%b want i=0 d=1", ibus_ready_o, dbus_ready_o); end
    step();
    ibus_avalid_i = 1'b0; dbus_avalid_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    n_checks++; if (dbus_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL lock_dbus_rvalid: got %b want 1", dbus_rvalid_o); end
    step();
    idle_inputs();
    $display("test_lock done");
  endtask

  task automatic test_write_then_read();
    apply_reset();
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h40; dbus_wdata_i = 32'h12345678;
    dbus_wstrb_i = 4'hF; mem_ready_i = 1'b1;
    #1;
    n_checks++; if (mem_wstrb_o !== 4'hF || mem_wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL wr_fields: got strb=%h data=%h want f 12345678", mem_wstrb_o, mem_wdata_o); end
    n_checks++; if (dbus_ready_o !== 1'b1) begin n_fail++; $display("FAIL wr_dbus_ready: got %b want 1", dbus_ready_o); end
    step();
    // stray response in IDLE must not reach either master
    dbus_avalid_i = 1'b0; dbus_wstrb_i = 4'h0;
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h50; mem_rvalid_i = 1'b1;
    #1;
    n_checks++; if (ibus_ready_o !== 1'b1 || mem_addr_o !== 32'h50) begin n_fail++; $display("FAIL wr_next_read: got ready=%b addr=%h want 1 00000050", ibus_ready_o, mem_addr_o); end
    n_checks++; if (ibus_rvalid_o !== 1'b0 || dbus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got i=%b d=%b want 0 0", ibus_rvalid_o, dbus_rvalid_o); end
    step();
    ibus_avalid_i = 1'b0;
    #1;
    n_checks++; if (ibus_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_read_rvalid: got %b want 1", ibus_rvalid_o); end
    step();
    idle_inputs();
    $display("test_write_then_read done");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ibus_avalid_i = 1'b1; ibus_addr_i = 32'h60; mem_ready_i = 1'b1;
    step();
    ibus_avalid_i = 1'b0; dbus_avalid_i = 1'b1; dbus_addr_i = 32'h70;
    #1;
    n_checks++; if (dbus_ready_o !== 1'b0 || mem_avalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_wait: got ready=%b avalid=%b want 0 0", dbus_ready_o, mem_avalid_o); end
    step();
    mem_rvalid_i = 1'b1;
    #1;
    n_checks++; if (ibus_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ibus_rvalid: got %b want 1", ibus_rvalid_o); end
    n_checks++; if (dbus_ready_o !== 1'b1 || mem_addr_o !== 32'h70) begin n_fail++; $display("FAIL b2b_dbus_accept: got ready=%b addr=%h want 1 00000070", dbus_ready_o, mem_addr_o); end
    step();
    dbus_avalid_i = 1'b0; ibus_avalid_i = 1'b1; mem_rvalid_i = 1'b0;
    #1;
    n_checks++; if (mem_avalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_in_wait_d: got avalid=%b want 0", mem_avalid_o); end
    step();
    ibus_avalid_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    n_checks++; if (dbus_rvalid_o !== 1'b1 || ibus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_dbus_rvalid: got i=%b d=%b want 0 1", ibus_rvalid_o, dbus_rvalid_o); end
    step();
    idle_inputs();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_abandon();
    apply_reset();
    dbus_avalid_i = 1'b1; dbus_addr_i = 32'h80; mem_ready_i = 1'b1;
    step();
    // reset while WAIT_D, with the clock enable off
    rst_n_i = 1'b0; cke_i = 1'b0;
    #1;
    n_checks++; if (dbus_ready_o !== 1'b0 || ibus_ready_o !== 1'b0) begin n_fail++; $display("FAIL abandon_ready_in_reset: got i=%b d=%b want 0 0", ibus_ready_o, dbus_ready_o); end
    step();
    rst_n_i = 1'b1; cke_i = 1'b1; dbus_avalid_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    n_checks++; if (dbus_rvalid_o !== 1'b0 || ibus_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL abandon_rvalid: got i=%b d=%b want 0 0", ibus_rvalid_o, dbus_rvalid_o); end
    step();
    idle_inputs();
    $display("test_reset_abandon done");
  endtask

  initial begin
    idle_inputs();
    rst_n_i = 1'b0;
    test_reset();
    test_ibus_read();
    test_contention();
    test_lock();
    test_write_then_read();
    test_back_to_back();
    test_reset_abandon();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
